// File: rtl/cmac_pkg.sv
// Shared types and constants for the complex MAC operand issuer / result collector.
package cmac_pkg;
    localparam int CMAC_N    = 16;
    localparam int GROUP_LEN = 4;

    typedef struct packed {
        logic signed [CMAC_N-1:0] re;
        logic signed [CMAC_N-1:0] im;
    } cplx_t;

    typedef struct packed {
        cplx_t a;
        cplx_t b;
    } cpair_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head word and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             rd_ok, wr_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A write into a full FIFO is legal only when the head leaves in the same cycle.
    assign rd_ok   = rd_en && (count_reg != '0);
    assign wr_ok   = wr_en && ((count_reg != CW'(DEPTH)) || rd_ok);
    assign rd_data = (count_reg == '0) ? '0 : mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (rd_ok)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/cmac_issue_ctrl.sv
// Buffers complex operand pairs, issues them to the MAC in gap-free groups of four,
// and collects MAC results under credit control so a result always has a slot.
module cmac_issue_ctrl
    import cmac_pkg::*;
#(
    parameter int N         = 16,
    parameter int IN_DEPTH  = 8,
    parameter int RES_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_ar,
    input  logic [N-1:0] s_ai,
    input  logic [N-1:0] s_br,
    input  logic [N-1:0] s_bi,
    output logic         mac_en,
    output logic [N-1:0] mac_ar,
    output logic [N-1:0] mac_ai,
    output logic [N-1:0] mac_br,
    output logic [N-1:0] mac_bi,
    input  logic         mac_result_valid,
    input  logic [N-1:0] mac_r_in,
    input  logic [N-1:0] mac_i_in,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_r,
    output logic [N-1:0] m_i,
    output logic         err_ovf
);
    localparam int ICW = $clog2(IN_DEPTH) + 1;
    localparam int RCW = $clog2(RES_DEPTH) + 1;
    localparam int BW  = $clog2(GROUP_LEN);

    logic [4*N-1:0]  in_head;
    logic [2*N-1:0]  res_head;
    logic [ICW-1:0]  in_count;
    logic [RCW-1:0]  res_count;
    logic [RCW-1:0]  outstanding_reg, outstanding_next;
    issue_state_t    state_reg, state_next;
    logic [BW-1:0]   beat_reg, beat_next;
    logic            mac_en_reg, mac_en_next;
    logic            err_ovf_reg;
    logic            s_push, m_pop, res_full, res_wr;
    logic            issue_pop, group_start, can_start;

    assign s_ready  = (in_count != ICW'(IN_DEPTH));
    assign s_push   = s_valid & s_ready;
    assign m_valid  = (res_count != '0);
    assign m_pop    = m_valid & m_ready;
    assign res_full = (res_count == RCW'(RES_DEPTH));
    assign res_wr   = mac_result_valid & (~res_full | m_pop);

    // Every issued group plus every held result must fit in the result FIFO.
    assign can_start = (in_count >= ICW'(GROUP_LEN)) &&
                       (({1'b0, outstanding_reg} + {1'b0, res_count}) < (RCW+1)'(RES_DEPTH));

    sync_fifo #(.WIDTH(4*N), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_push),
        .wr_data ({s_ar, s_ai, s_br, s_bi}),
        .rd_en   (issue_pop),
        .rd_data (in_head),
        .count   (in_count)
    );

    sync_fifo #(.WIDTH(2*N), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (res_wr),
        .wr_data ({mac_r_in, mac_i_in}),
        .rd_en   (m_pop),
        .rd_data (res_head),
        .count   (res_count)
    );

    assign m_r = res_head[2*N-1:N];
    assign m_i = res_head[N-1:0];

    // beat_reg is the index of the next beat; zero in ISSUE means beat 3 is on the bus.
    always_comb begin
        state_next  = state_reg;
        beat_next   = beat_reg;
        mac_en_next = mac_en_reg;
        issue_pop   = 1'b0;
        group_start = 1'b0;
        if ((state_reg == ISSUE) && (beat_reg != '0)) begin
            issue_pop = 1'b1;
            beat_next = (beat_reg == BW'(GROUP_LEN - 1)) ? '0 : beat_reg + BW'(1);
        end else if (can_start) begin
            issue_pop   = 1'b1;
            group_start = 1'b1;
            state_next  = ISSUE;
            beat_next   = BW'(1);
            mac_en_next = 1'b1;
        end else begin
            state_next  = IDLE;
            mac_en_next = 1'b0;
        end
    end

    // Saturates at zero so a stray result after reset cannot underflow the credit count.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (group_start && !mac_result_valid)
            outstanding_next = outstanding_reg + RCW'(1);
        else if (!group_start && mac_result_valid && (outstanding_reg != '0))
            outstanding_next = outstanding_reg - RCW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            beat_reg        <= '0;
            mac_en_reg      <= 1'b0;
            outstanding_reg <= '0;
            err_ovf_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            beat_reg        <= beat_next;
            mac_en_reg      <= mac_en_next;
            outstanding_reg <= outstanding_next;
            if (mac_result_valid && res_full && !m_pop)
                err_ovf_reg <= 1'b1;
        end
    end

    // Lane 0..3 = ar, ai, br, bi in the packed operand word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [N-1:0] lane_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                lane_reg <= '0;
            else if (issue_pop)
                lane_reg <= in_head[(4-gi)*N-1 -: N];
        end
    end

    assign mac_en  = mac_en_reg;
    assign mac_ar  = g_lane[0].lane_reg;
    assign mac_ai  = g_lane[1].lane_reg;
    assign mac_br  = g_lane[2].lane_reg;
    assign mac_bi  = g_lane[3].lane_reg;
    assign err_ovf = err_ovf_reg;
endmodule

// File: tb/tb_cmac_issue_ctrl.sv
// Scoreboard bench: operand order at the MAC, Q8.8 MAC model results, credit stall and overflow.
`timescale 1ns/1ps
module tb_cmac_issue_ctrl;
    import cmac_pkg::*;

    localparam int N         = 16;
    localparam int IN_DEPTH  = 8;
    localparam int RES_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid, s_ready;
    logic [N-1:0] s_ar, s_ai, s_br, s_bi;
    logic         mac_en;
    logic [N-1:0] mac_ar, mac_ai, mac_br, mac_bi;
    logic         mac_result_valid;
    logic [N-1:0] mac_r_in, mac_i_in;
    logic         m_valid, m_ready;
    logic [N-1:0] m_r, m_i;
    logic         err_ovf;

    always #5 clk = ~clk;

    cmac_issue_ctrl #(.N(N), .IN_DEPTH(IN_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_ar(s_ar), .s_ai(s_ai), .s_br(s_br), .s_bi(s_bi),
        .mac_en(mac_en), .mac_ar(mac_ar), .mac_ai(mac_ai), .mac_br(mac_br), .mac_bi(mac_bi),
        .mac_result_valid(mac_result_valid), .mac_r_in(mac_r_in), .mac_i_in(mac_i_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_r(m_r), .m_i(m_i),
        .err_ovf(err_ovf)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    cpair_t         op_q [$];
    logic [2*N-1:0] exp_q [$];
    longint         in_acc_r = 0, in_acc_i = 0;
    int             in_beats = 0;
    int             group_cnt = 0, beat_total = 0, run_len = 0, last_run = 0, res_seen = 0;
    logic           inj_valid = 1'b0;
    logic [N-1:0]   inj_r = '0, inj_i = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint prod_re(input cpair_t p);
        return (longint'($signed(p.a.re)) * longint'($signed(p.b.re)) -
                longint'($signed(p.a.im)) * longint'($signed(p.b.im))) >>> 8;
    endfunction

    function automatic longint prod_im(input cpair_t p);
        return (longint'($signed(p.a.re)) * longint'($signed(p.b.im)) +
                longint'($signed(p.a.im)) * longint'($signed(p.b.re))) >>> 8;
    endfunction

    function automatic cpair_t mk(input logic [N-1:0] ar, input logic [N-1:0] ai,
                                  input logic [N-1:0] br, input logic [N-1:0] bi);
        cpair_t p;
        p.a.re = ar; p.a.im = ai; p.b.re = br; p.b.im = bi;
        return p;
    endfunction

    function automatic cpair_t rnd_pair();
        return mk(N'($urandom), N'($urandom), N'($urandom), N'($urandom));
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_pair(input cpair_t p);
        int guard;
        guard = 0;
        s_valid = 1'b1;
        s_ar = p.a.re; s_ai = p.a.im; s_br = p.b.re; s_bi = p.b.im;
        @(negedge clk);
        while (!s_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            check("push_timeout", s_ready, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        op_q.push_back(p);
        in_acc_r += prod_re(p);
        in_acc_i += prod_im(p);
        in_beats++;
        if (in_beats == GROUP_LEN) begin
            exp_q.push_back({N'(in_acc_r), N'(in_acc_i)});
            in_acc_r = 0; in_acc_i = 0; in_beats = 0;
        end
    endtask

    task automatic inject(input logic [N-1:0] r, input logic [N-1:0] i, input logic rdy);
        inj_r = r; inj_i = i; inj_valid = 1'b1; m_ready = rdy;
        @(posedge clk); #1;
        inj_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // MAC model plus output monitor, sampled on the falling edge.
    initial begin
        int     beat_n;
        longint acc_r, acc_i;
        logic   fire;
        logic [N-1:0] fr, fi;
        cpair_t obs;
        logic [2*N-1:0] exp_res;
        beat_n = 0; acc_r = 0; acc_i = 0; fr = '0; fi = '0;
        mac_result_valid = 1'b0; mac_r_in = '0; mac_i_in = '0;
        forever begin
            @(negedge clk);
            fire = 1'b0;
            if (rst) begin
                beat_n = 0; acc_r = 0; acc_i = 0; run_len = 0;
            end else begin
                if (mac_en) begin
                    run_len++;
                    beat_total++;
                    obs = mk(mac_ar, mac_ai, mac_br, mac_bi);
                    if (op_q.size() == 0)
                        check("mac_extra_beat", op_q.size(), 1);
                    else
                        check("mac_operands", obs, op_q.pop_front());
                    acc_r += prod_re(obs);
                    acc_i += prod_im(obs);
                    beat_n++;
                    if (beat_n == GROUP_LEN) begin
                        fire = 1'b1; fr = N'(acc_r); fi = N'(acc_i);
                        beat_n = 0; acc_r = 0; acc_i = 0;
                        group_cnt++;
                    end
                end else if (run_len != 0) begin
                    last_run = run_len;
                    run_len = 0;
                end
                if (m_valid && m_ready) begin
                    res_seen++;
                    $display("result %0d: r=%h i=%h", res_seen, m_r, m_i);
                    if (exp_q.size() == 0)
                        check("res_extra", exp_q.size(), 1);
                    else begin
                        exp_res = exp_q.pop_front();
                        check("res_data", {m_r, m_i}, exp_res);
                    end
                end
            end
            mac_result_valid = fire | inj_valid;
            mac_r_in = fire ? fr : (inj_valid ? inj_r : '0);
            mac_i_in = fire ? fi : (inj_valid ? inj_i : '0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, b0;
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        s_ar = '0; s_ai = '0; s_br = '0; s_bi = '0;
        wait_cycles(3);

        check("rst_s_ready", s_ready, 1);
        check("rst_mac_en",  mac_en, 0);
        check("rst_mac_ops", {mac_ar, mac_ai, mac_br, mac_bi}, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data",  {m_r, m_i}, 0);
        check("rst_err_ovf", err_ovf, 0);
        rst = 1'b0;
        wait_cycles(1);

        // Single group, result held until m_ready.
        for (int k = 0; k < 4; k++) push_pair(mk(16'h0100, 16'h0000, 16'h0200, 16'h0000));
        wait_cycles(10);
        check("single_run", last_run, 4);
        check("single_m_valid", m_valid, 1);
        check("single_m_r", m_r, 16'h0800);
        check("single_m_i", m_i, 16'h0000);
        m_ready = 1'b1;
        wait_cycles(3);
        check("single_drain", exp_q.size(), 0);
        check("single_m_valid_off", m_valid, 0);

        // Partial group waits; fourth pair launches the burst on the next edge.
        b0 = beat_total;
        for (int k = 0; k < 3; k++) push_pair(rnd_pair());
        wait_cycles(20);
        check("partial_no_issue", beat_total - b0, 0);
        push_pair(rnd_pair());
        check("partial_not_yet", mac_en, 0);
        wait_cycles(1);
        check("partial_start", mac_en, 1);
        wait_cycles(10);
        check("partial_run", last_run, 4);
        check("partial_drain", exp_q.size(), 0);

        // Back-to-back groups.
        g0 = group_cnt;
        for (int k = 0; k < 8; k++) push_pair(rnd_pair());
        wait_cycles(15);
        check("b2b_run", last_run, 8);
        check("b2b_groups", group_cnt - g0, 2);
        check("b2b_drain", exp_q.size(), 0);

        // Credit stall with consumer blocked.
        m_ready = 1'b0;
        g0 = group_cnt;
        for (int k = 0; k < 24; k++) push_pair(rnd_pair());
        wait_cycles(10);
        b0 = beat_total;
        wait_cycles(20);
        check("stall_groups", group_cnt - g0, 4);
        check("stall_no_beats", beat_total - b0, 0);
        check("stall_s_ready", s_ready, 0);
        check("stall_err_ovf", err_ovf, 0);
        m_ready = 1'b1;
        wait_cycles(1);
        m_ready = 1'b0;
        wait_cycles(20);
        check("stall_one_more", group_cnt - g0, 5);
        check("stall_s_ready_back", s_ready, 1);
        check("stall_err_ovf2", err_ovf, 0);
        m_ready = 1'b1;
        wait_cycles(40);
        check("stall_all_groups", group_cnt - g0, 6);
        check("stall_drain", exp_q.size(), 0);

        // Result write and pop together while full.
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) push_pair(rnd_pair());
        wait_cycles(20);
        check("sim_full_valid", m_valid, 1);
        exp_q.push_back({16'h1234, 16'h5678});
        $display("inject r=1234 i=5678 with pop");
        inject(16'h1234, 16'h5678, 1'b1);
        check("sim_err_ovf", err_ovf, 0);
        check("sim_m_valid", m_valid, 1);
        m_ready = 1'b1;
        wait_cycles(10);
        check("sim_drain", exp_q.size(), 0);

        // Result strobe while full with no pop: dropped, sticky flag.
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) push_pair(rnd_pair());
        wait_cycles(20);
        $display("inject r=dead i=beef without pop");
        inject(16'hdead, 16'hbeef, 1'b0);
        check("ovf_set", err_ovf, 1);
        m_ready = 1'b1;
        wait_cycles(10);
        check("ovf_drain", exp_q.size(), 0);
        check("ovf_m_valid", m_valid, 0);
        check("ovf_sticky", err_ovf, 1);

        // Reset during beat 2 of a burst.
        for (int k = 0; k < 4; k++) push_pair(rnd_pair());
        wait_cycles(3);
        check("mid_beat2_en", mac_en, 1);
        rst = 1'b1;
        op_q.delete(); exp_q.delete();
        in_acc_r = 0; in_acc_i = 0; in_beats = 0;
        #1;
        check("mid_rst_mac_en", mac_en, 0);
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_err_ovf", err_ovf, 0);
        check("mid_rst_mac_ar", mac_ar, 0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        g0 = group_cnt;
        for (int k = 0; k < 4; k++) push_pair(rnd_pair());
        wait_cycles(10);
        check("post_rst_run", last_run, 4);
        check("post_rst_groups", group_cnt - g0, 1);
        check("post_rst_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
